// File: rtl/clock_compare_divider.sv
// clock_compare_divider
// Free-running counter compared against a programmable period and duty to
// produce a registered divided clock, a period tick and gt/lt/eq flags.
// New period/duty values wait in shadow registers until the period boundary,
// so the output never shows a truncated or runt pulse.
module clock_compare_divider #(
    parameter int                WIDTH      = 7,
    parameter logic [WIDTH-1:0]  RST_PERIOD = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RST_DUTY   = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_period_in,
    input  logic [WIDTH-1:0] i_duty_in,
    output logic             o_load_ack,
    output logic             o_pending,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_count,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic [WIDTH-1:0] r_duty, w_duty_nxt;
    logic [WIDTH-1:0] r_sh_period, w_sh_period_nxt;
    logic [WIDTH-1:0] r_sh_duty, w_sh_duty_nxt;
    logic             r_pending, w_pending_nxt;
    logic             r_load_ack, w_load_ack_nxt;
    logic             r_clk_out, r_tick, r_gt, r_lt, r_eq;
    logic             w_wrap, w_boundary, w_run_nxt;

    // Next-state logic: run/idle decision, counter advance and the
    // shadow-register handshake. A load arriving on a boundary edge bypasses
    // the shadow registers and is applied directly at that edge.
    always_comb begin
        w_state_nxt     = i_enable ? S_RUN : S_IDLE;
        w_wrap          = (r_state == S_RUN) && (r_count == r_period);
        w_boundary      = (r_state == S_IDLE) || w_wrap;
        w_period_nxt    = r_period;
        w_duty_nxt      = r_duty;
        w_sh_period_nxt = r_sh_period;
        w_sh_duty_nxt   = r_sh_duty;
        w_pending_nxt   = r_pending;
        w_load_ack_nxt  = 1'b0;

        if (i_load && w_boundary) begin
            w_period_nxt   = i_period_in;
            w_duty_nxt     = i_duty_in;
            w_pending_nxt  = 1'b0;
            w_load_ack_nxt = 1'b1;
        end else if (i_load) begin
            w_sh_period_nxt = i_period_in;
            w_sh_duty_nxt   = i_duty_in;
            w_pending_nxt   = 1'b1;
        end else if (r_pending && w_boundary) begin
            w_period_nxt   = r_sh_period;
            w_duty_nxt     = r_sh_duty;
            w_pending_nxt  = 1'b0;
            w_load_ack_nxt = 1'b1;
        end

        // Only a running, still-enabled, non-wrapping counter advances;
        // everything else (wrap, idle, leaving RUN) restarts at zero.
        if ((r_state == S_RUN) && i_enable && !w_wrap)
            w_count_nxt = r_count + 1'b1;
        else
            w_count_nxt = '0;

        w_run_nxt = (w_state_nxt == S_RUN);
    end

    // State and output registers; outputs are computed from the next-state
    // count and duty so they line up with the count they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_period    <= RST_PERIOD;
            r_duty      <= RST_DUTY;
            r_sh_period <= RST_PERIOD;
            r_sh_duty   <= RST_DUTY;
            r_pending   <= 1'b0;
            r_load_ack  <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_period    <= w_period_nxt;
            r_duty      <= w_duty_nxt;
            r_sh_period <= w_sh_period_nxt;
            r_sh_duty   <= w_sh_duty_nxt;
            r_pending   <= w_pending_nxt;
            r_load_ack  <= w_load_ack_nxt;
            r_clk_out   <= w_run_nxt && (w_count_nxt <  w_duty_nxt);
            r_lt        <= w_run_nxt && (w_count_nxt <  w_duty_nxt);
            r_gt        <= w_run_nxt && (w_count_nxt >  w_duty_nxt);
            r_eq        <= w_run_nxt && (w_count_nxt == w_duty_nxt);
            r_tick      <= w_run_nxt && (w_count_nxt == w_period_nxt);
        end
    end

    assign o_load_ack = r_load_ack;
    assign o_pending  = r_pending;
    assign o_clk_out  = r_clk_out;
    assign o_tick     = r_tick;
    assign o_count    = r_count;
    assign o_gt       = r_gt;
    assign o_lt       = r_lt;
    assign o_eq       = r_eq;

endmodule

// File: tb/tb_clock_compare_divider.sv
// Bench for clock_compare_divider (WIDTH=7): a reset/first-period vector
// table, directed sequences for the handshake and duty corner cases, and a
// randomized run, all checked against a behavioural model.
module tb_clock_compare_divider;

    localparam int W = 7;

    logic         i_clk = 1'b0;
    logic         i_reset, i_enable, i_load;
    logic [W-1:0] i_period_in, i_duty_in;
    logic         o_load_ack, o_pending, o_clk_out, o_tick, o_gt, o_lt, o_eq;
    logic [W-1:0] o_count;

    int checks = 0;
    int failures = 0;

    clock_compare_divider #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_load(i_load),
        .i_period_in(i_period_in), .i_duty_in(i_duty_in),
        .o_load_ack(o_load_ack), .o_pending(o_pending), .o_clk_out(o_clk_out),
        .o_tick(o_tick), .o_count(o_count), .o_gt(o_gt), .o_lt(o_lt), .o_eq(o_eq)
    );

    always #5 i_clk = ~i_clk;

    // behavioural model state
    bit         m_run, m_pend, m_ack;
    logic [W-1:0] m_count, m_per, m_duty, m_sp, m_sd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input bit rst, en, ld, input logic [W-1:0] p, d);
        bit wrap, bnd;
        int nc;
        if (rst) begin
            m_run = 0; m_count = 0; m_per = 7'd127; m_duty = 7'd64;
            m_pend = 0; m_ack = 0;
        end else begin
            wrap  = m_run && (m_count == m_per);
            bnd   = !m_run || wrap;
            nc    = (m_run && en && !wrap) ? int'(m_count) + 1 : 0;
            m_ack = 0;
            if (ld && bnd) begin
                m_per = p; m_duty = d; m_pend = 0; m_ack = 1;
            end else if (ld) begin
                m_sp = p; m_sd = d; m_pend = 1;
            end else if (m_pend && bnd) begin
                m_per = m_sp; m_duty = m_sd; m_pend = 0; m_ack = 1;
            end
            m_count = W'(nc);
            m_run   = en;
        end
    endtask

    task automatic model_check();
        logic [6:0] exp_f, got_f;
        exp_f = {m_ack, m_pend,
                 m_run && (m_count <  m_duty),
                 m_run && (m_count == m_per),
                 m_run && (m_count >  m_duty),
                 m_run && (m_count <  m_duty),
                 m_run && (m_count == m_duty)};
        got_f = {o_load_ack, o_pending, o_clk_out, o_tick, o_gt, o_lt, o_eq};
        chk("model_count", o_count, m_count);
        chk("model_flags{ack,pend,clk,tick,gt,lt,eq}", got_f, exp_f);
    endtask

    // Apply inputs, advance one edge, sample 1ns later and compare to model.
    task automatic cyc(input bit rst, en, ld, input logic [W-1:0] p, d);
        i_reset = rst; i_enable = en; i_load = ld; i_period_in = p; i_duty_in = d;
        model_step(rst, en, ld, p, d);
        @(posedge i_clk); #1;
        model_check();
    endtask

    // Load and keep running until the ack appears (bounded).
    task automatic load_wait(input string name, input logic [W-1:0] p, d);
        bit seen;
        cyc(0, 1, 1, p, d);
        seen = o_load_ack;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc(0, 1, 0, 0, 0);
            seen = o_load_ack;
        end
        chk(name, seen, 1);
    endtask

    typedef struct {
        bit rst, en, ld;
        logic [W-1:0] p, d;
        logic [W-1:0] count;
        bit clk, tick, eq, ack, pend;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int acks, highs, eqs, ticks, cnt_at_ack;
        bit got_tick;

        i_reset = 1; i_enable = 0; i_load = 0; i_period_in = 0; i_duty_in = 0;
        m_sp = 0; m_sd = 0;

        //          rst en ld  p  d   count clk tick eq ack pend
        tbl[0]  = '{1, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1,  9, 5,  0,  0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0,  0, 0,  0,  1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0,  0, 0,  1,  1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0,  0, 0,  2,  1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0,  0, 0,  3,  1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0,  0, 0,  4,  1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0,  0, 0,  5,  0, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 0,  0, 0,  6,  0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0,  0, 0,  7,  0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0,  0, 0,  8,  0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0,  0, 0,  9,  0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 0,  0, 0,  0,  1, 0, 0, 0, 0};

        // 1: reset, load 9/5 in IDLE, first period 5 high / 5 low
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].p, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), o_count, tbl[i].count);
            chk($sformatf("tbl%0d_clk_tick_eq_ack_pend", i),
                {o_clk_out, o_tick, o_eq, o_load_ack, o_pending},
                {tbl[i].clk, tbl[i].tick, tbl[i].eq, tbl[i].ack, tbl[i].pend});
        end

        // 2: load 3/1 while count=2; applied at the count=9 wrap
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("t2_at_count2", o_count, 2);
        cyc(0, 1, 1, 3, 1);
        chk("t2_pending_set", o_pending, 1);
        acks = 0; cnt_at_ack = -1;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (o_load_ack) begin acks++; cnt_at_ack = int'(o_count); end
        end
        chk("t2_single_ack", acks, 1);
        chk("t2_ack_at_count0", cnt_at_ack, 0);

        // 3: two loads inside one period -> one ack, 6/3 active
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      cyc(0, 1, 1, 4, 2);
            else if (k == 1) cyc(0, 1, 1, 6, 3);
            else             cyc(0, 1, 0, 0, 0);
            if (o_load_ack) acks++;
        end
        chk("t3_single_ack", acks, 1);
        got_tick = 0;
        for (int k = 0; k < 10 && !got_tick; k++) begin
            cyc(0, 1, 0, 0, 0);
            got_tick = o_tick;
        end
        chk("t3_tick_seen", got_tick, 1);
        highs = 0;
        for (int k = 0; k < 7; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (o_clk_out) highs++;
        end
        chk("t3_high_cycles", highs, 3);

        // 4: duty boundaries
        load_wait("t4_ack_duty0", 9, 0);
        highs = 0;
        for (int k = 0; k < 10; k++) begin cyc(0, 1, 0, 0, 0); if (o_clk_out) highs++; end
        chk("t4_duty0_highs", highs, 0);
        load_wait("t4_ack_duty12", 9, 12);
        highs = 0; eqs = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (o_clk_out) highs++;
            if (o_eq) eqs++;
        end
        chk("t4_duty12_highs", highs, 10);
        chk("t4_duty12_eqs", eqs, 0);
        load_wait("t4_ack_period0", 0, 1);
        highs = 0; ticks = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (o_clk_out) highs++;
            if (o_tick) ticks++;
        end
        chk("t4_period0_highs", highs, 5);
        chk("t4_period0_ticks", ticks, 5);

        // 5: drop enable at count=4, then re-enable
        load_wait("t5_ack", 9, 5);
        for (int k = 0; k < 20 && o_count != 4; k++) cyc(0, 1, 0, 0, 0);
        chk("t5_reached_count4", o_count, 4);
        cyc(0, 0, 0, 0, 0);
        chk("t5_idle_count_clk_tick", {o_count, o_clk_out, o_tick}, 9'd0);
        cyc(0, 1, 0, 0, 0);
        chk("t5_restart_count", o_count, 0);
        chk("t5_restart_clk", o_clk_out, 1);

        // 6: reset while pending at count=7, then load+reset together
        for (int k = 0; k < 20 && o_count != 5; k++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 3, 3);
        for (int k = 0; k < 20 && o_count != 7; k++) cyc(0, 1, 0, 0, 0);
        chk("t6_pending_before_reset", {o_pending, o_count}, {1'b1, 7'd7});
        cyc(1, 1, 0, 0, 0);
        chk("t6_reset_state", {o_pending, o_load_ack, o_count, o_clk_out, o_tick, o_gt, o_lt, o_eq}, 0);
        acks = 0;
        for (int k = 0; k < 5; k++) begin cyc(0, 1, 0, 0, 0); if (o_load_ack) acks++; end
        chk("t6_no_ack_after_reset", acks, 0);
        cyc(1, 1, 1, 5, 2);
        chk("t6_load_with_reset", {o_pending, o_load_ack}, 2'b00);
        acks = 0; ticks = 0;
        for (int k = 0; k < 130; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (o_load_ack) acks++;
            if (o_tick) ticks++;
        end
        chk("t6_default_period_ticks", ticks, 1);
        chk("t6_default_no_ack", acks, 0);

        // randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 300) == 0, ($urandom % 16) != 0, ($urandom % 10) == 0,
                W'($urandom_range(0, 15)), W'($urandom_range(0, 18)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
